// File: rtl/lc3_dp_pkg.sv
// Shared types and encodings for the LC-3 datapath with handshake memory port.
//   mem_state_t : memory-port FSM states (also exported for debug)
//   PCMUX_*     : PC source selects
//   ADDR2_*     : second address-adder operand selects
//   ALUK_*      : ALU operation selects
//   CC_RESET    : condition code after reset ({N,Z,P} = Z)
package lc3_dp_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2,
    MEM_ERR  = 2'd3
  } mem_state_t;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDR  = 2'b10;
  localparam logic [1:0] PCMUX_HOLD  = 2'b11;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD    = 2'b00;
  localparam logic [1:0] ALUK_AND    = 2'b01;
  localparam logic [1:0] ALUK_NOT    = 2'b10;
  localparam logic [1:0] ALUK_PASSA  = 2'b11;

  localparam logic [2:0] CC_RESET    = 3'b010;

endpackage

// File: rtl/lc3_mem_port.sv
// Memory-port sequencer: turns a one-cycle mem_start into a held request,
// counts wait states, and reports completion or timeout as one-cycle pulses.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem_start, mem_we   start pulse (only honoured in IDLE) and its direction
//   mar, mdr            operands captured at start
//   mem_req/mem_wr      request and write qualifier to memory
//   mem_addr/mem_wdata  captured operands, stable for the whole access
//   mem_ready           completion from memory (only looked at in REQ)
//   mem_busy/done/err   status: in REQ / completion pulse / timeout pulse
//   rd_load             read completing this cycle: parent loads MDR from rdata
//   state_dbg           current FSM state
//
// Handshake: mem_req rises the cycle after an accepted mem_start and stays
// high until the first cycle in which mem_ready is sampled high (that edge
// completes the access) or until TIMEOUT wait cycles have been counted and
// the next one also lacks mem_ready. mem_addr, mem_wdata and mem_wr do not
// change while mem_req is high.
module lc3_mem_port
  import lc3_dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_start,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              rd_load,
  output mem_state_t        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd_load = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (mem_start) begin
          state_d = MEM_REQ;
          cnt_d   = '0;
          addr_d  = mar;
          wdata_d = mdr;
          we_d    = mem_we;
        end
      end
      MEM_REQ: begin
        // Ready is checked first so a late completion still wins over timeout.
        if (mem_ready) begin
          state_d = MEM_DONE;
          rd_load = ~we_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d = MEM_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      MEM_ERR:  state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
    end
  end

  assign mem_req   = (state_q == MEM_REQ);
  assign mem_busy  = mem_req;
  assign mem_wr    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_done  = (state_q == MEM_DONE);
  assign mem_err   = (state_q == MEM_ERR);
  assign state_dbg = state_q;

endmodule

// File: rtl/lc3_datapath_mem.sv
// LC-3 datapath: PC/IR/MAR/MDR, 8-entry register file, ALU, address adder,
// condition codes, branch enable and LED latch, with a handshake memory port.
// Ports:
//   Clk, Reset                   clock, synchronous active-high reset
//   LD_*                         register load enables
//   Gate*                        bus drivers (more than one -> bus 0, bus_conflict)
//   ADDR1MUX,SR1MUX,SR2MUX,DRMUX operand selects; PCMUX,ADDR2MUX,ALUK 2-bit selects
//   mem_*                        memory port (see lc3_mem_port)
//   bus_conflict                 more than one Gate active this cycle
//   PC,IR,MAR,MDR,ALU,CC,BEN,LED architectural state / ALU result
//   mem_state_dbg                memory-port FSM state
module lc3_datapath_mem
  import lc3_dp_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LED_W   = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              LD_PC,
  input  logic              LD_IR,
  input  logic              LD_CC,
  input  logic              LD_BEN,
  input  logic              LD_REG,
  input  logic              LD_LED,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateMARMUX,
  input  logic              GateALU,
  input  logic              ADDR1MUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  input  logic              DRMUX,
  input  logic [1:0]        PCMUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              mem_start,
  input  logic              mem_we,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              bus_conflict,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] ALU,
  output logic [2:0]        CC,
  output logic              BEN,
  output logic [LED_W-1:0]  LED,
  output mem_state_t        mem_state_dbg
);

  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [2:0]        cc_q, cc_d;
  logic              ben_q, ben_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];

  logic [DATA_W-1:0] bus, alu_out, addr_sum, addr1, addr2, sr1_val, sr2_val, alu_b;
  logic [3:0]        gates;
  logic [2:0]        sr1_idx, dr_idx;
  logic              rd_load;
  logic              cc_n, cc_z;
  logic              unused_ir_bits;

  // Opcode bits are decoded by the control FSM, not here.
  assign unused_ir_bits = ^ir_q[DATA_W-1:12];

  lc3_mem_port #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_mem_port (
    .clk       (Clk),
    .reset     (Reset),
    .mem_start (mem_start),
    .mem_we    (mem_we),
    .mar       (mar_q),
    .mdr       (mdr_q),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_busy  (mem_busy),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .rd_load   (rd_load),
    .state_dbg (mem_state_dbg)
  );

  // Operand selection, address adder and ALU.
  always_comb begin
    sr1_idx = SR1MUX ? ir_q[8:6] : ir_q[11:9];
    dr_idx  = DRMUX ? 3'd7 : ir_q[11:9];
    sr1_val = rf_q[sr1_idx];
    sr2_val = rf_q[ir_q[2:0]];
    alu_b   = SR2MUX ? {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]} : sr2_val;

    addr1 = ADDR1MUX ? sr1_val : pc_q;
    case (ADDR2MUX)
      ADDR2_ZERO:  addr2 = '0;
      ADDR2_OFF6:  addr2 = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
      ADDR2_OFF9:  addr2 = {{(DATA_W-9){ir_q[8]}}, ir_q[8:0]};
      default:     addr2 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};
    endcase
    addr_sum = addr1 + addr2;

    case (ALUK)
      ALUK_ADD: alu_out = sr1_val + alu_b;
      ALUK_AND: alu_out = sr1_val & alu_b;
      ALUK_NOT: alu_out = ~sr1_val;
      default:  alu_out = sr1_val;
    endcase
  end

  // Bus: a single driver passes through; none or several give 0 with no
  // priority so a control bug shows up as a zero bus rather than a silent win.
  assign gates        = {GatePC, GateMDR, GateMARMUX, GateALU};
  assign bus_conflict = ($countones(gates) > 1);

  always_comb begin
    case (gates)
      4'b1000: bus = pc_q;
      4'b0100: bus = mdr_q;
      4'b0010: bus = addr_sum;
      4'b0001: bus = alu_out;
      default: bus = '0;
    endcase
  end

  assign cc_n = bus[DATA_W-1];
  assign cc_z = (bus == '0);

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    cc_d  = cc_q;
    ben_d = ben_q;
    led_d = led_q;
    rf_d  = rf_q;

    if (LD_PC) begin
      case (PCMUX)
        PCMUX_INC:  pc_d = pc_q + DATA_W'(1);
        PCMUX_BUS:  pc_d = bus;
        PCMUX_ADDR: pc_d = addr_sum;
        default:    pc_d = pc_q;
      endcase
    end
    if (LD_IR)  ir_d  = bus;
    if (LD_MAR) mar_d = bus;
    // Read completion owns MDR on that edge.
    if (rd_load)     mdr_d = mem_rdata;
    else if (LD_MDR) mdr_d = bus;
    if (LD_CC)  cc_d  = {cc_n, cc_z, ~cc_n & ~cc_z};
    // Uses the registered CC, so a same-edge LD_CC does not affect BEN.
    if (LD_BEN) ben_d = (ir_q[11] & cc_q[2]) | (ir_q[10] & cc_q[1]) | (ir_q[9] & cc_q[0]);
    if (LD_LED) led_d = ir_q[LED_W-1:0];
    if (LD_REG) rf_d[dr_idx] = bus;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      cc_q  <= CC_RESET;
      ben_q <= 1'b0;
      led_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      cc_q  <= cc_d;
      ben_q <= ben_d;
      led_q <= led_d;
      for (int i = 0; i < 8; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign PC  = pc_q;
  assign IR  = ir_q;
  assign MAR = mar_q;
  assign MDR = mdr_q;
  assign ALU = alu_out;
  assign CC  = cc_q;
  assign BEN = ben_q;
  assign LED = led_q;

endmodule

// File: tb/tb_lc3_datapath_mem.sv
module tb_lc3_datapath_mem;
  import lc3_dp_pkg::*;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset = 1'b1;
  logic LD_MAR = 0, LD_MDR = 0, LD_PC = 0, LD_IR = 0, LD_CC = 0, LD_BEN = 0, LD_REG = 0, LD_LED = 0;
  logic GatePC = 0, GateMDR = 0, GateMARMUX = 0, GateALU = 0;
  logic ADDR1MUX = 0, SR1MUX = 0, SR2MUX = 0, DRMUX = 0;
  logic [1:0] PCMUX = 0, ADDR2MUX = 0, ALUK = 0;
  logic mem_start = 0, mem_we = 0, mem_ready = 0;
  logic [15:0] mem_rdata = 0;
  logic [31:0] mem_rdata32 = 0;

  logic mem_req, mem_wr, mem_busy, mem_done, mem_err, bus_conflict, BEN;
  logic [15:0] mem_addr, mem_wdata, PC, IR, MAR, MDR, ALU;
  logic [2:0] CC;
  logic [9:0] LED;
  mem_state_t st16, st32;

  logic mem_req32, mem_wr32, mem_busy32, mem_done32, mem_err32, bus_conflict32, BEN32;
  logic [31:0] mem_addr32, mem_wdata32, PC32, IR32, MAR32, MDR32, ALU32;
  logic [2:0] CC32;
  logic [9:0] LED32;

  lc3_datapath_mem #(.DATA_W(16), .LED_W(10), .TIMEOUT(TMO)) dut (
    .Clk(clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_CC(LD_CC),
    .LD_BEN(LD_BEN), .LD_REG(LD_REG), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateMARMUX(GateMARMUX), .GateALU(GateALU),
    .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .mem_start(mem_start), .mem_we(mem_we), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err), .bus_conflict(bus_conflict),
    .PC(PC), .IR(IR), .MAR(MAR), .MDR(MDR), .ALU(ALU), .CC(CC), .BEN(BEN), .LED(LED),
    .mem_state_dbg(st16)
  );

  lc3_datapath_mem #(.DATA_W(32), .LED_W(10), .TIMEOUT(TMO)) dut32 (
    .Clk(clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_PC(LD_PC), .LD_IR(LD_IR), .LD_CC(LD_CC),
    .LD_BEN(LD_BEN), .LD_REG(LD_REG), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateMARMUX(GateMARMUX), .GateALU(GateALU),
    .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .DRMUX(DRMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .mem_start(mem_start), .mem_we(mem_we), .mem_req(mem_req32), .mem_wr(mem_wr32),
    .mem_addr(mem_addr32), .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata32), .mem_ready(mem_ready),
    .mem_busy(mem_busy32), .mem_done(mem_done32), .mem_err(mem_err32), .bus_conflict(bus_conflict32),
    .PC(PC32), .IR(IR32), .MAR(MAR32), .MDR(MDR32), .ALU(ALU32), .CC(CC32), .BEN(BEN32), .LED(LED32),
    .mem_state_dbg(st32)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (16-bit instance) ----------------
  bit          model_valid = 0;
  logic [15:0] m_pc, m_ir, m_mar, m_mdr;
  logic [15:0] m_rf [8];
  logic [2:0]  m_cc;
  logic        m_ben;
  logic [9:0]  m_led;
  bit          m_in_req, m_done, m_err, m_we;
  int          m_waits;
  logic [15:0] m_addr, m_wdata;

  function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = v;
    for (int i = bits; i < 16; i++) r[i] = v[bits-1];
    return r;
  endfunction

  function automatic logic [15:0] m_sr1();
    return SR1MUX ? m_rf[m_ir[8:6]] : m_rf[m_ir[11:9]];
  endfunction

  function automatic logic [15:0] m_alu();
    logic [15:0] a, b;
    a = m_sr1();
    b = SR2MUX ? sx(m_ir, 5) : m_rf[m_ir[2:0]];
    case (ALUK)
      2'd0: return a + b;
      2'd1: return a & b;
      2'd2: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic logic [15:0] m_addr_sum();
    logic [15:0] base, off;
    base = ADDR1MUX ? m_sr1() : m_pc;
    case (ADDR2MUX)
      2'd0: off = 16'h0;
      2'd1: off = sx(m_ir, 6);
      2'd2: off = sx(m_ir, 9);
      default: off = sx(m_ir, 11);
    endcase
    return base + off;
  endfunction

  function automatic int m_ngates();
    return int'(GatePC) + int'(GateMDR) + int'(GateMARMUX) + int'(GateALU);
  endfunction

  function automatic logic [15:0] m_bus();
    if (m_ngates() != 1) return 16'h0;
    if (GatePC)     return m_pc;
    if (GateMDR)    return m_mdr;
    if (GateMARMUX) return m_addr_sum();
    return m_alu();
  endfunction

  always @(posedge clk) begin
    logic [15:0] b, ad, old_mar, old_mdr;
    if (Reset) begin
      model_valid = 1;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_cc = 3'b010; m_ben = 0; m_led = 0;
      for (int i = 0; i < 8; i++) m_rf[i] = 0;
      m_in_req = 0; m_done = 0; m_err = 0; m_we = 0; m_waits = 0; m_addr = 0; m_wdata = 0;
    end else if (model_valid) begin
      b = m_bus();
      ad = m_addr_sum();
      old_mar = m_mar;
      old_mdr = m_mdr;
      if (LD_LED) m_led = m_ir[9:0];
      if (LD_BEN) m_ben = (m_ir[11] && m_cc == 3'b100) || (m_ir[10] && m_cc == 3'b010) ||
                          (m_ir[9] && m_cc == 3'b001);
      if (LD_REG) m_rf[DRMUX ? 7 : int'(m_ir[11:9])] = b;
      if (LD_CC) m_cc = b[15] ? 3'b100 : (b == 0) ? 3'b010 : 3'b001;
      if (LD_IR) m_ir = b;
      if (LD_MAR) m_mar = b;
      if (LD_MDR) m_mdr = b;
      if (LD_PC) begin
        if (PCMUX == 2'd0) m_pc = m_pc + 1;
        else if (PCMUX == 2'd1) m_pc = b;
        else if (PCMUX == 2'd2) m_pc = ad;
      end
      if (m_in_req) begin
        if (mem_ready) begin
          m_in_req = 0; m_done = 1;
          if (!m_we) m_mdr = mem_rdata;
        end else if (m_waits == TMO) begin
          m_in_req = 0; m_err = 1;
        end else begin
          m_waits++;
        end
      end else if (m_done || m_err) begin
        m_done = 0; m_err = 0;
      end else if (mem_start) begin
        m_in_req = 1; m_waits = 0; m_addr = old_mar; m_wdata = old_mdr; m_we = mem_we;
      end
    end
  end

  // Single compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("pc", PC, m_pc);
      chk("ir", IR, m_ir);
      chk("mar", MAR, m_mar);
      chk("mdr", MDR, m_mdr);
      chk("alu", ALU, m_alu());
      chk("cc", CC, m_cc);
      chk("ben", BEN, m_ben);
      chk("led", LED, m_led);
      chk("bus_conflict", bus_conflict, m_ngates() > 1);
      chk("mem_req", mem_req, m_in_req);
      chk("mem_busy", mem_busy, m_in_req);
      chk("mem_done", mem_done, m_done);
      chk("mem_err", mem_err, m_err);
      if (m_in_req) begin
        chk("mem_wr", mem_wr, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    LD_MAR = 0; LD_MDR = 0; LD_PC = 0; LD_IR = 0; LD_CC = 0; LD_BEN = 0; LD_REG = 0; LD_LED = 0;
    GatePC = 0; GateMDR = 0; GateMARMUX = 0; GateALU = 0;
    ADDR1MUX = 0; SR1MUX = 0; SR2MUX = 0; DRMUX = 0; PCMUX = 0; ADDR2MUX = 0; ALUK = 0;
  endtask

  task automatic mem_read(input logic [15:0] d16, input logic [31:0] d32, input int waits,
                          output int req_n, output int done_n);
    mem_rdata = d16; mem_rdata32 = d32;
    mem_we = 0; mem_start = 1;
    tick();
    mem_start = 0;
    req_n = 0;
    repeat (waits) begin
      if (mem_req) req_n++;
      tick();
    end
    if (mem_req) req_n++;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    done_n = int'(mem_done);
    tick();
    done_n += int'(mem_done);
  endtask

  task automatic load_mdr(input logic [15:0] d16, input logic [31:0] d32);
    int rq, dn;
    mem_read(d16, d32, 0, rq, dn);
  endtask

  task automatic set_ir(input logic [15:0] v);
    load_mdr(v, {16'h0, v});
    GateMDR = 1; LD_IR = 1;
    tick();
    clear_ctrl();
  endtask

  task automatic set_reg(input logic [2:0] r, input logic [15:0] d16, input logic [31:0] d32);
    set_ir({4'h0, r, 9'h0});
    load_mdr(d16, d32);
    GateMDR = 1; LD_REG = 1;
    tick();
    clear_ctrl();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rq, dn, n;
    clear_ctrl();
    tick();
    tick();
    Reset = 0;
    chk("reset_pc", PC, 16'h0);
    chk("reset_cc", CC, 3'b010);
    chk("reset_mem_req", mem_req, 1'b0);

    // PC increment x3
    LD_PC = 1; PCMUX = 2'b00;
    repeat (3) tick();
    clear_ctrl();
    chk("pc_inc3", PC, 16'h0003);

    // Reset in the middle of a request
    load_mdr(16'h8000, 32'h8000_0000);
    GateMDR = 1; LD_CC = 1;
    tick();
    clear_ctrl();
    chk("cc_neg_pre_reset", CC, 3'b100);
    mem_start = 1;
    tick();
    mem_start = 0;
    tick();
    chk("req_before_reset", mem_req, 1'b1);
    Reset = 1;
    tick();
    Reset = 0;
    chk("req_after_reset", mem_req, 1'b0);
    chk("cc_after_reset", CC, 3'b010);
    chk("pc_after_reset", PC, 16'h0);

    // Read with 3 wait states
    load_mdr(16'h3000, 32'h3000);
    GateMDR = 1; LD_MAR = 1;
    tick();
    clear_ctrl();
    chk("mar_3000", MAR, 16'h3000);
    mem_read(16'hBEEF, 32'hBEEF, 3, rq, dn);
    chk("read_req_cycles", rq, 4);
    chk("read_done_pulses", dn, 1);
    chk("read_mdr", MDR, 16'hBEEF);

    // Write: operands frozen while MDR changes underneath
    set_reg(3'd0, 16'h5555, 32'h5555);
    load_mdr(16'h1234, 32'h1234);
    mem_we = 1; mem_start = 1;
    tick();
    mem_start = 0; mem_we = 0;
    GateALU = 1; ALUK = 2'b11; LD_MDR = 1;
    tick();
    clear_ctrl();
    chk("wr_mdr_changed", MDR, 16'h5555);
    chk("wr_wdata_held", mem_wdata, 16'h1234);
    chk("wr_qualifier", mem_wr, 1'b1);
    tick();
    chk("wr_wdata_held2", mem_wdata, 16'h1234);
    mem_rdata = 16'hDEAD;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    chk("wr_done", mem_done, 1'b1);
    chk("wr_mdr_untouched", MDR, 16'h5555);
    tick();

    // Timeout: ready never comes
    mem_we = 0; mem_start = 1;
    tick();
    mem_start = 0;
    n = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", n, TMO + 1);
    chk("tmo_err_pulse", mem_err, 1'b1);
    chk("tmo_mdr_kept", MDR, 16'h5555);
    tick();
    chk("tmo_err_cleared", mem_err, 1'b0);
    chk("tmo_idle", mem_busy, 1'b0);

    // Bus conflict
    GateMDR = 1; LD_CC = 1;
    tick();
    clear_ctrl();
    chk("cc_pos", CC, 3'b001);
    GatePC = 1; GateALU = 1; LD_CC = 1; LD_MAR = 1;
    #1;
    chk("conflict_flag", bus_conflict, 1'b1);
    tick();
    clear_ctrl();
    #1;
    chk("conflict_cc", CC, 3'b010);
    chk("conflict_mar", MAR, 16'h0);
    chk("conflict_clear", bus_conflict, 1'b0);

    // CC / BEN
    set_ir(16'h0A00);
    load_mdr(16'h8000, 32'h8000_0000);
    GateMDR = 1; LD_CC = 1;
    tick();
    clear_ctrl();
    chk("cc_neg", CC, 3'b100);
    LD_BEN = 1;
    tick();
    clear_ctrl();
    chk("ben_np", BEN, 1'b1);
    set_ir(16'h0400);
    LD_BEN = 1;
    tick();
    clear_ctrl();
    chk("ben_z", BEN, 1'b0);

    // PC <- PC + SEXT(IR[8:0]) with offset -1
    set_ir(16'h01FF);
    ADDR1MUX = 0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1;
    tick();
    clear_ctrl();
    chk("pc_addr_adder", PC, 16'hFFFF);
    chk("pc_addr_adder32", PC32, 32'hFFFF_FFFF);

    // ADD R2, R1, #1 with R1 at the positive limit
    set_reg(3'd1, 16'h7FFF, 32'h7FFF_FFFF);
    set_ir(16'h1461);
    SR1MUX = 1; SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1;
    #1;
    chk("add_alu16", ALU, 16'h8000);
    chk("add_alu32", ALU32, 32'h8000_0000);
    tick();
    clear_ctrl();
    chk("add_cc16", CC, 3'b100);
    chk("add_cc32", CC32, 3'b100);
    LD_LED = 1;
    tick();
    clear_ctrl();
    chk("led", LED, 10'h061);
    chk("led32", LED32, 10'h061);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
